// File: rtl/fifo_rr_scheduler_pkg.sv
// Shared types and build-time defaults for the FIFO round-robin read scheduler.
// Defaults track the front-end constants; a prior definition from constants.vh takes precedence.
`ifndef FE_DATA_W
`define FE_DATA_W 32
`endif
`ifndef NUM_FE_SRC
`define NUM_FE_SRC 4
`endif
`ifndef FE_BURST_MAX
`define FE_BURST_MAX 4
`endif

package fifo_rr_scheduler_pkg;

  localparam int FE_DATA_W_DEF    = `FE_DATA_W;
  localparam int NUM_FE_SRC_DEF   = `NUM_FE_SRC;
  localparam int FE_BURST_MAX_DEF = `FE_BURST_MAX;

  // Output buffer entries; also the ceiling on buffered-plus-in-flight beats.
  localparam int BUF_DEPTH = 2;

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } sched_state_t;

endpackage

// File: rtl/fifo_rr_scheduler_rr_pick.sv
// Rotating first-one search: the lowest requesting index at or above ptr, wrapping
// around to index 0.
module rr_pick
  import fifo_rr_scheduler_pkg::*;
#(
  parameter int NUM_SRC = 4,
  parameter int SRC_W   = $clog2(NUM_SRC)
) (
  input  logic [NUM_SRC-1:0] req,
  input  logic [SRC_W-1:0]   ptr,
  output logic [SRC_W-1:0]   gnt_idx,
  output logic               any
);

  logic [SRC_W:0] cand;

  // Scan the offsets from the far end downward so that the nearest hit is written last.
  always_comb begin
    gnt_idx = '0;
    cand    = '0;
    any     = |req;
    for (int k = NUM_SRC - 1; k >= 0; k--) begin
      cand = {1'b0, ptr} + (SRC_W + 1)'(k);
      if (cand >= (SRC_W + 1)'(NUM_SRC)) begin
        cand = cand - (SRC_W + 1)'(NUM_SRC);
      end
      if (req[cand[SRC_W-1:0]]) begin
        gnt_idx = cand[SRC_W-1:0];
      end
    end
  end

endmodule

// File: rtl/fifo_rr_scheduler.sv
// Round-robin read scheduler: bursts reads from NUM_SRC registered-read FIFOs into a
// 2-entry valid/ready buffer, tagging each beat with its source index.
module fifo_rr_scheduler
  import fifo_rr_scheduler_pkg::*;
#(
  parameter int NUM_SRC   = NUM_FE_SRC_DEF,
  parameter int DATA_W    = FE_DATA_W_DEF,
  parameter int BURST_MAX = FE_BURST_MAX_DEF,
  localparam int SRC_W    = $clog2(NUM_SRC)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      cfg_en,
  input  logic [NUM_SRC-1:0]        src_empty,
  output logic [NUM_SRC-1:0]        src_r_en,
  input  logic [NUM_SRC*DATA_W-1:0] src_data,
  output logic                      m_valid,
  input  logic                      m_ready,
  output logic [DATA_W-1:0]         m_data,
  output logic [SRC_W-1:0]          m_src_id,
  output logic                      busy
);

  localparam int CNT_W = $clog2(BURST_MAX + 1);

  sched_state_t      state;
  logic [SRC_W-1:0]  g;
  logic [SRC_W-1:0]  rr_ptr;
  logic [SRC_W-1:0]  next_ptr;
  logic [CNT_W-1:0]  beat_cnt;
  logic              inflight;
  logic [SRC_W-1:0]  inflight_id;
  logic [DATA_W-1:0] buf_data [BUF_DEPTH];
  logic [SRC_W-1:0]  buf_id   [BUF_DEPTH];
  logic              rd_ptr;
  logic              wr_ptr;
  logic [1:0]        buf_cnt;
  logic [2:0]        pend;
  logic              credit;
  logic              pop_out;
  logic              issue;
  logic              burst_done;
  logic [SRC_W-1:0]  pick_idx;
  logic              pick_any;
  logic [DATA_W-1:0] src_word [NUM_SRC];

  for (genvar gi = 0; gi < NUM_SRC; gi++) begin : g_split
    assign src_word[gi] = src_data[gi*DATA_W +: DATA_W];
  end

  rr_pick #(
    .NUM_SRC (NUM_SRC),
    .SRC_W   (SRC_W)
  ) u_rr_pick (
    .req     (~src_empty),
    .ptr     (rr_ptr),
    .gnt_idx (pick_idx),
    .any     (pick_any)
  );

  // Credit counts the beat already in flight so the buffer can never be overrun.
  assign pop_out    = m_valid && m_ready;
  assign pend       = 3'(buf_cnt) + 3'(inflight) - 3'(pop_out);
  assign credit     = pend < 3'(BUF_DEPTH);
  assign issue      = (state == BURST) && !src_empty[g] && credit;
  assign burst_done = (state == BURST) &&
                      ((issue && beat_cnt == CNT_W'(BURST_MAX - 1)) || src_empty[g]);
  assign next_ptr   = (g == SRC_W'(NUM_SRC - 1)) ? '0 : g + 1'b1;

  always_comb begin
    src_r_en = '0;
    if (issue) begin
      src_r_en[g] = 1'b1;
    end
  end

  assign m_valid  = buf_cnt != 2'd0;
  assign m_data   = buf_data[rd_ptr];
  assign m_src_id = buf_id[rd_ptr];
  assign busy     = (state == BURST) || inflight || (buf_cnt != 2'd0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      g           <= '0;
      rr_ptr      <= '0;
      beat_cnt    <= '0;
      inflight    <= 1'b0;
      inflight_id <= '0;
      rd_ptr      <= 1'b0;
      wr_ptr      <= 1'b0;
      buf_cnt     <= '0;
      for (int i = 0; i < BUF_DEPTH; i++) begin
        buf_data[i] <= '0;
        buf_id[i]   <= '0;
      end
    end else begin
      // The tag travels with the pop, so a grant change never re-labels a landing beat.
      inflight <= issue;
      if (issue) begin
        inflight_id <= g;
      end
      if (inflight) begin
        buf_data[wr_ptr] <= src_word[inflight_id];
        buf_id[wr_ptr]   <= inflight_id;
        wr_ptr           <= ~wr_ptr;
      end
      if (pop_out) begin
        rd_ptr <= ~rd_ptr;
      end
      case ({inflight, pop_out})
        2'b10:   buf_cnt <= buf_cnt + 2'd1;
        2'b01:   buf_cnt <= buf_cnt - 2'd1;
        default: ;
      endcase

      case (state)
        IDLE: begin
          if (cfg_en && pick_any) begin
            g        <= pick_idx;
            beat_cnt <= '0;
            state    <= BURST;
          end
        end
        BURST: begin
          if (issue) begin
            beat_cnt <= beat_cnt + 1'b1;
          end
          if (burst_done) begin
            state  <= IDLE;
            rr_ptr <= next_ptr;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
